// File: rtl/module_status_pkg.sv
// module_status_pkg: shared state encoding, read-select codes and status bit positions
package module_status_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, STALL = 2'd2} state_t;
  localparam logic [2:0] SEL_START = 3'd0, SEL_DONE = 3'd1, SEL_BUSY = 3'd2, SEL_STALL = 3'd3,
                         SEL_LAST = 3'd4, SEL_MAX = 3'd5, SEL_STATUS = 3'd6, SEL_OVF = 3'd7;
  localparam int ST_STATE_LSB = 0, ST_OVF_ANY = 2;
endpackage

// File: rtl/module_status_channel.sv
// module_status_channel: one channel's handshake FSM, saturating counters and latency (in: clock, reset, en, clr, ap_*; out: vals[0..7], busy)
module module_status_channel
  import module_status_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter bit READY_ONLY = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  ap_start,
  input  logic                  ap_ready,
  input  logic                  ap_done,
  input  logic                  ap_continue,
  output logic [7:0][CNT_W-1:0] vals,
  output logic                  busy
);
  localparam logic [CNT_W-1:0] MAX = '1;
  state_t state, state_n;
  logic [CNT_W-1:0] start_cnt, done_cnt, busy_cyc, stall_cyc, lat, last_lat, max_lat;
  logic lat_ovf, begin_txn, done_b, inc_start;
  logic [7:0] ovf;
  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] x);
    return x == MAX ? x : x + CNT_W'(1);
  endfunction
  always_comb begin
    state_n = READY_ONLY ? IDLE :
              state == IDLE ? (ap_start ? BUSY : IDLE) :
              state == BUSY ? (!ap_done ? BUSY : !ap_continue ? STALL : ap_start ? BUSY : IDLE) :
              (!ap_continue ? STALL : ap_start ? BUSY : IDLE);
    begin_txn = state_n == BUSY && (state != BUSY || ap_done);
    done_b = state == BUSY && ap_done;
    inc_start = READY_ONLY ? ap_ready : ap_start && ap_ready;
    ovf = {2'b0, max_lat == MAX, lat_ovf, stall_cyc == MAX, busy_cyc == MAX, done_cnt == MAX, start_cnt == MAX};
    vals = '0;
    vals[SEL_START] = start_cnt;
    vals[SEL_DONE] = done_cnt;
    vals[SEL_BUSY] = busy_cyc;
    vals[SEL_STALL] = stall_cyc;
    vals[SEL_LAST] = last_lat;
    vals[SEL_MAX] = max_lat;
    vals[SEL_STATUS][ST_OVF_ANY] = |ovf;
    vals[SEL_STATUS][ST_STATE_LSB +: 2] = state;
    vals[SEL_OVF] = CNT_W'(ovf);
  end
  assign busy = state != IDLE;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      {start_cnt, done_cnt, busy_cyc, stall_cyc, lat, last_lat, max_lat, lat_ovf} <= '0;
    end else if (clr) begin
      state <= IDLE;
      {start_cnt, done_cnt, busy_cyc, stall_cyc, lat, last_lat, max_lat, lat_ovf} <= '0;
    end else if (en) begin
      state <= state_n;
      if (inc_start) start_cnt <= sat(start_cnt);
      if (done_b) done_cnt <= sat(done_cnt);
      if (state == BUSY) busy_cyc <= sat(busy_cyc);
      if (state == STALL) stall_cyc <= sat(stall_cyc);
      // lat counts BUSY cycles since the accepting edge, so it equals L when done is sampled
      if (begin_txn) lat <= CNT_W'(1);
      else if (state == BUSY) lat <= sat(lat);
      if (state == BUSY && lat == MAX) lat_ovf <= 1'b1;
      if (done_b) begin
        last_lat <= lat;
        if (lat > max_lat) max_lat <= lat;
      end
    end
endmodule

// File: rtl/module_status_monitor.sv
// module_status_monitor: N_CH-channel HLS handshake monitor with freeze/clear and registered read port (in: clock, reset, finish, clear, ap_*, rd_req/rd_ch/rd_sel; out: rd_valid, rd_data, frozen, any_busy)
module module_status_monitor
  import module_status_pkg::*;
#(
  parameter int              N_CH       = 10,
  parameter int              CNT_W      = 32,
  parameter logic [N_CH-1:0] READY_ONLY = '0,
  parameter int              CH_W       = N_CH > 1 ? $clog2(N_CH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             finish,
  input  logic             clear,
  input  logic [N_CH-1:0]  ap_start,
  input  logic [N_CH-1:0]  ap_ready,
  input  logic [N_CH-1:0]  ap_done,
  input  logic [N_CH-1:0]  ap_continue,
  input  logic             rd_req,
  input  logic [CH_W-1:0]  rd_ch,
  input  logic [2:0]       rd_sel,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic             frozen,
  output logic             any_busy
);
  logic [N_CH-1:0][7:0][CNT_W-1:0] vals;
  logic [N_CH-1:0] busy;
  logic [CNT_W-1:0] sel;
  logic en;
  // the cycle finish is raised already holds state
  assign en = !(frozen || finish);
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    module_status_channel #(.CNT_W(CNT_W), .READY_ONLY(READY_ONLY[g])) u_ch (
      .clock(clock), .reset(reset), .en(en), .clr(clear),
      .ap_start(ap_start[g]), .ap_ready(ap_ready[g]), .ap_done(ap_done[g]), .ap_continue(ap_continue[g]),
      .vals(vals[g]), .busy(busy[g])
    );
  end
  always_comb begin
    sel = '0;
    for (int i = 0; i < N_CH; i++) if (rd_ch == CH_W'(i)) sel = vals[i][rd_sel];
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      {frozen, any_busy, rd_valid, rd_data} <= '0;
    end else if (clear) begin
      {frozen, any_busy, rd_valid, rd_data} <= '0;
    end else begin
      frozen <= frozen || finish;
      any_busy <= |busy;
      rd_valid <= rd_req;
      if (rd_req) rd_data <= sel;
    end
endmodule

// File: tb/tb_module_status_monitor.sv
// tb_module_status_monitor: directed self-checking bench for module_status_monitor
module tb_module_status_monitor;
  localparam int N_CH = 10, CNT_W = 8, CH_W = 4;
  logic clock = 1'b0, reset = 1'b0, finish = 1'b0, clear = 1'b0, rd_req = 1'b0;
  logic [N_CH-1:0] ap_start = '0, ap_ready = '0, ap_done = '0, ap_continue = '0;
  logic [CH_W-1:0] rd_ch = '0;
  logic [2:0] rd_sel = '0;
  logic rd_valid, frozen, any_busy;
  logic [CNT_W-1:0] rd_data;
  int n_chk = 0, n_fail = 0;

  module_status_monitor #(.N_CH(N_CH), .CNT_W(CNT_W), .READY_ONLY(10'h200)) dut (
    .clock(clock), .reset(reset), .finish(finish), .clear(clear),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .rd_req(rd_req), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_valid(rd_valid), .rd_data(rd_data), .frozen(frozen), .any_busy(any_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic rd(input int ch, input int sel, input logic [63:0] exp, input string tag);
    rd_req = 1'b1;
    rd_ch = CH_W'(ch);
    rd_sel = 3'(sel);
    tick();
    rd_req = 1'b0;
    check({tag, "_valid"}, rd_valid, 1);
    check(tag, rd_data, exp);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    tick(2);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_frozen", frozen, 0);
    check("rst_any_busy", any_busy, 0);
    reset = 1'b1;
    tick();
    rd(0, 0, 0, "rst_start_cnt");
    rd(0, 6, 0, "rst_status");

    // single transaction, L=5
    ap_start[0] = 1; ap_ready[0] = 1;
    tick();
    ap_start[0] = 0; ap_ready[0] = 0;
    check("busy_rise_lag", any_busy, 0);
    tick(4);
    check("busy_high", any_busy, 1);
    ap_done[0] = 1; ap_continue[0] = 1;
    tick();
    ap_done[0] = 0; ap_continue[0] = 0;
    check("busy_fall_lag", any_busy, 1);
    tick();
    check("busy_fall", any_busy, 0);
    rd(0, 0, 1, "t1_start_cnt");
    rd(0, 1, 1, "t1_done_cnt");
    rd(0, 2, 5, "t1_busy_cyc");
    rd(0, 4, 5, "t1_last_lat");
    rd(0, 5, 5, "t1_max_lat");
    rd(0, 6, 0, "t1_status");

    // stall of 3 cycles
    do_clear();
    ap_start[0] = 1; ap_ready[0] = 1;
    tick();
    ap_start[0] = 0; ap_ready[0] = 0;
    tick(2);
    ap_done[0] = 1;
    tick();
    ap_done[0] = 0;
    rd(0, 6, 2, "st_status_stall");
    tick();
    ap_continue[0] = 1;
    tick();
    ap_continue[0] = 0;
    check("st_busy_lag", any_busy, 1);
    tick();
    check("st_busy_fall", any_busy, 0);
    rd(0, 3, 3, "st_stall_cyc");
    rd(0, 6, 0, "st_status_idle");
    rd(0, 1, 1, "st_done_cnt");

    // L=7 then back-to-back L=3
    do_clear();
    ap_start[0] = 1; ap_ready[0] = 1;
    tick();
    ap_start[0] = 0; ap_ready[0] = 0;
    tick(6);
    ap_done[0] = 1; ap_continue[0] = 1; ap_start[0] = 1; ap_ready[0] = 1;
    tick();
    ap_start[0] = 0; ap_ready[0] = 0; ap_done[0] = 0; ap_continue[0] = 0;
    tick(2);
    ap_done[0] = 1; ap_continue[0] = 1;
    tick();
    ap_done[0] = 0; ap_continue[0] = 0;
    rd(0, 4, 3, "b2b_last_lat");
    rd(0, 5, 7, "b2b_max_lat");
    rd(0, 0, 2, "b2b_start_cnt");
    rd(0, 1, 2, "b2b_done_cnt");
    rd(0, 2, 10, "b2b_busy_cyc");

    // ready-only channel 9
    do_clear();
    for (int i = 0; i < 4; i++) begin
      ap_ready[9] = 1; ap_start[9] = 1;
      tick();
      ap_ready[9] = 0; ap_start[9] = 0;
      tick();
    end
    check("ro_any_busy", any_busy, 0);
    rd(9, 0, 4, "ro_start_cnt");
    rd(9, 1, 0, "ro_done_cnt");
    rd(9, 6, 0, "ro_status");
    ap_ready[9] = 1;
    tick(300);
    ap_ready[9] = 0;
    rd(9, 0, 255, "sat_start_cnt");
    rd(9, 7, 1, "sat_ovf_mask");
    rd(9, 6, 4, "sat_status");

    // freeze
    do_clear();
    ap_start[0] = 1; ap_ready[0] = 1;
    tick();
    ap_start[0] = 0; ap_ready[0] = 0;
    tick(2);
    finish = 1;
    tick();
    finish = 0;
    check("frz_frozen", frozen, 1);
    ap_start[0] = 1; ap_ready[0] = 1; ap_done[0] = 1; ap_continue[0] = 1; ap_ready[9] = 1;
    tick(3);
    ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '0;
    check("frz_any_busy", any_busy, 1);
    rd(0, 0, 1, "frz_start_cnt");
    rd(0, 1, 0, "frz_done_cnt");
    rd(0, 6, 1, "frz_status");
    rd(9, 0, 0, "frz_ro_start");
    rd(0, 2, 2, "frz_busy_cyc");
    tick();
    check("hold_rd_valid", rd_valid, 0);
    check("hold_rd_data", rd_data, 2);
    rd(10, 0, 0, "rd_oob");
    check("frz_still", frozen, 1);

    // clear unfreezes
    do_clear();
    check("clr_frozen", frozen, 0);
    check("clr_any_busy", any_busy, 0);
    check("clr_rd_data", rd_data, 0);
    rd(0, 2, 0, "clr_busy_cyc");
    rd(0, 0, 0, "clr_start_cnt");
    rd(0, 6, 0, "clr_status");

    // async reset mid-BUSY
    ap_start[0] = 1; ap_ready[0] = 1;
    tick();
    ap_start[0] = 0; ap_ready[0] = 0;
    tick(2);
    rd(0, 0, 1, "pre_rst_start");
    check("pre_rst_busy", any_busy, 1);
    reset = 1'b0;
    #2;
    check("arst_any_busy", any_busy, 0);
    check("arst_rd_data", rd_data, 0);
    check("arst_rd_valid", rd_valid, 0);
    tick();
    reset = 1'b1;
    tick();
    rd(0, 6, 0, "arst_status");
    rd(0, 2, 0, "arst_busy_cyc");
    rd(0, 4, 0, "arst_last_lat");
    rd(0, 0, 0, "arst_start_cnt");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
